// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: queues bus commands in a small FIFO and replays
// them one at a time as SETUP/ACCESS transfers on an APB-style bus.
//
// Ports:
//   pclk, Reset         clock, synchronous active-high reset
//   cmd_valid/ready     command push handshake
//   cmd_write/sel/addr  command fields (sel 1 = GPIO, 2 = UART)
//   cmd_wdata           write payload
//   transfer, penable   bus phase strobes
//   pwrite, Psel        bus direction and slave select
//   write_paddr         address for writes (0 otherwise)
//   apb_read_paddr      address for reads (0 otherwise)
//   write_data          payload for writes (0 otherwise)
//   bus_ready           slave ready during ACCESS
//   apb_read_data_out   read data from the bus
//   rsp_valid/data/err  one-cycle completion report
//   busy                FIFO non-empty or transfer in flight
//
// Build option: define APB_SEQ_TIMEOUT_EN to abort ACCESS phases
// that see TIMEOUT consecutive not-ready cycles.

module apb_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_sel,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        transfer,
  output logic        penable,
  output logic        pwrite,
  output logic [1:0]  Psel,
  output logic [4:0]  write_paddr,
  output logic [4:0]  apb_read_paddr,
  output logic [31:0] write_data,
  input  logic        bus_ready,
  input  logic [31:0] apb_read_data_out,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 40;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  logic [EW-1:0] head;
  logic          head_write;
  logic [1:0]    head_sel;
  logic [4:0]    head_addr;
  logic [31:0]   head_wdata;
  logic          head_ok;

  logic        cur_write;
  logic [1:0]  cur_sel;
  logic [4:0]  cur_addr;
  logic [31:0] cur_wdata;

  logic [31:0] rsp_data_q;
  logic        err_q;
  logic        tmo_hit;

  // Ready comes from the registered count only, so a same-cycle
  // pop never makes room for a push.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !Reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && !empty && !Reset;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    if (p == AW'(FIFO_DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_write, cmd_sel,
                      cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge pclk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign head_write = head[39];
  assign head_sel   = head[38:37];
  assign head_addr  = head[36:32];
  assign head_wdata = head[31:0];
  assign head_ok    = (head_sel == 2'd1) ||
                      (head_sel == 2'd2);

`ifdef APB_SEQ_TIMEOUT_EN
  logic [3:0] tmo_q;

  // Fires on the not-ready ACCESS cycle that would bring the
  // count to TIMEOUT.
  assign tmo_hit = (state_q == ACCESS) && !bus_ready &&
                   (tmo_q == 4'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (Reset) begin
      tmo_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_q <= '0;
    end else if (state_q == ACCESS && !bus_ready) begin
      tmo_q <= tmo_q + 4'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Invalid selects skip the bus and go straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = head_ok ? SETUP : DONE;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus_ready || tmo_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields are latched at pop so the bus stays stable
  // from SETUP through the final ACCESS cycle.
  always_ff @(posedge pclk) begin
    if (Reset) begin
      cur_write  <= 1'b0;
      cur_sel    <= '0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) begin
        cur_write <= head_write;
        cur_sel   <= head_sel;
        cur_addr  <= head_addr;
        cur_wdata <= head_wdata;
        err_q     <= !head_ok;
        if (!head_ok) rsp_data_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (bus_ready) begin
          rsp_data_q <= cur_write ? '0 : apb_read_data_out;
        end else if (tmo_hit) begin
          rsp_data_q <= '0;
          err_q      <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    transfer       = 1'b0;
    penable        = 1'b0;
    pwrite         = 1'b0;
    Psel           = '0;
    write_paddr    = '0;
    apb_read_paddr = '0;
    write_data     = '0;
    rsp_valid      = 1'b0;
    rsp_err        = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        SETUP, ACCESS: begin
          transfer = 1'b1;
          penable  = (state_q == ACCESS);
          pwrite   = cur_write;
          Psel     = cur_sel;
          if (cur_write) begin
            write_paddr = cur_addr;
            write_data  = cur_wdata;
          end else begin
            apb_read_paddr = cur_addr;
          end
        end
        DONE: begin
          rsp_valid = 1'b1;
          rsp_err   = err_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_data = Reset ? '0 : rsp_data_q;
  assign busy     = !Reset &&
                    (!empty || state_q != IDLE);

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed bench for apb_cmd_sequencer.
// Inputs change 1ns after rising edges; outputs sampled on falling edges.

module tb_apb_cmd_sequencer;

  logic        pclk = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_sel;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        transfer;
  logic        penable;
  logic        pwrite;
  logic [1:0]  Psel;
  logic [4:0]  write_paddr;
  logic [4:0]  apb_read_paddr;
  logic [31:0] write_data;
  logic        bus_ready;
  logic [31:0] apb_read_data_out;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  logic [31:0] rd_fix;
  logic        echo;

  int n_chk = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  assign apb_read_data_out =
    echo ? {16'hC0DE, 11'h0, apb_read_paddr} : rd_fix;

  apb_cmd_sequencer #(
    .FIFO_DEPTH(4),
    .TIMEOUT(15)
  ) dut (
    .pclk(pclk),
    .Reset(Reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .transfer(transfer),
    .penable(penable),
    .pwrite(pwrite),
    .Psel(Psel),
    .write_paddr(write_paddr),
    .apb_read_paddr(apb_read_paddr),
    .write_data(write_data),
    .bus_ready(bus_ready),
    .apb_read_data_out(apb_read_data_out),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge pclk);
    #1;
  endtask

  task automatic mid();
    @(negedge pclk);
  endtask

  task automatic put(
    input logic        w,
    input logic [1:0]  s,
    input logic [4:0]  a,
    input logic [31:0] d
  );
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic load(input int k);
    if (k == 2) put(1'b1, 2'd1, 5'(10 + k), 32'hFACE_0000);
    else        put(1'b0, 2'd2, 5'(10 + k), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nrsp;
    int seen;
    logic pushed;
    logic [31:0] ed;

    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_sel   = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    bus_ready = 1'b1;
    rd_fix    = '0;
    echo      = 1'b0;

    // reset state
    nxt();
    nxt();
    mid();
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_xfer", transfer, 0);
    check("rst_rsp", rsp_valid, 0);
    nxt();
    Reset = 1'b0;
    mid();
    check("rel_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_data", rsp_data, 0);
    nxt();

    // single write, bus_ready tied high
    put(1'b1, 2'd1, 5'd3, 32'hA5A5_0001);
    mid();
    check("w_c0_xfer", transfer, 0);
    nxt();
    cmd_valid = 1'b0;
    mid();
    check("w_c1_busy", busy, 1);
    check("w_c1_xfer", transfer, 0);
    nxt();
    mid();
    check("w_setup_xfer", transfer, 1);
    check("w_setup_pen", penable, 0);
    check("w_setup_pwr", pwrite, 1);
    check("w_setup_psel", Psel, 1);
    check("w_setup_wa", write_paddr, 3);
    check("w_setup_ra", apb_read_paddr, 0);
    check("w_setup_wd", write_data, 32'hA5A5_0001);
    nxt();
    mid();
    check("w_acc_xfer", transfer, 1);
    check("w_acc_pen", penable, 1);
    check("w_acc_wa", write_paddr, 3);
    check("w_acc_wd", write_data, 32'hA5A5_0001);
    nxt();
    mid();
    check("w_done_vld", rsp_valid, 1);
    check("w_done_err", rsp_err, 0);
    check("w_done_data", rsp_data, 0);
    check("w_done_xfer", transfer, 0);
    nxt();
    mid();
    check("w_after_vld", rsp_valid, 0);
    check("w_after_busy", busy, 0);
    nxt();

    // read with three wait states
    bus_ready = 1'b0;
    rd_fix    = 32'hDEAD_BEEF;
    put(1'b0, 2'd2, 5'd5, 32'h1234_5678);
    mid();
    nxt();
    cmd_valid = 1'b0;
    mid();
    nxt();
    mid();
    check("r_setup_ra", apb_read_paddr, 5);
    check("r_setup_wa", write_paddr, 0);
    check("r_setup_wd", write_data, 0);
    check("r_setup_pwr", pwrite, 0);
    check("r_setup_psel", Psel, 2);
    check("r_setup_pen", penable, 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      mid();
      check("r_wait_pen", penable, 1);
      check("r_wait_ra", apb_read_paddr, 5);
      check("r_wait_vld", rsp_valid, 0);
      nxt();
    end
    bus_ready = 1'b1;
    mid();
    check("r_last_pen", penable, 1);
    check("r_last_ra", apb_read_paddr, 5);
    nxt();
    mid();
    check("r_done_vld", rsp_valid, 1);
    check("r_done_data", rsp_data, 32'hDEAD_BEEF);
    check("r_done_err", rsp_err, 0);
    nxt();
    rd_fix = 32'h0;
    mid();
    check("r_hold_vld", rsp_valid, 0);
    check("r_hold_data", rsp_data, 32'hDEAD_BEEF);
    nxt();

    // reset pulse clears the held response
    Reset = 1'b1;
    mid();
    check("rp_ready", cmd_ready, 0);
    check("rp_data", rsp_data, 0);
    nxt();
    Reset = 1'b0;
    mid();
    check("rp_post_data", rsp_data, 0);
    check("rp_post_ready", cmd_ready, 1);
    nxt();

    // six commands back to back; FIFO fills at cycle 5
    echo = 1'b1;
    k    = 0;
    nrsp = 0;
    load(0);
    for (int c = 0; c < 40; c++) begin
      mid();
      if (c == 4) check("b2b_ready_c4", cmd_ready, 1);
      if (c == 5) check("b2b_ready_c5", cmd_ready, 0);
      if (c == 6) check("b2b_ready_c6", cmd_ready, 1);
      if (rsp_valid) begin
        if (nrsp == 2) ed = 32'h0;
        else ed = {16'hC0DE, 11'h0, 5'(10 + nrsp)};
        check("b2b_data", rsp_data, ed);
        check("b2b_err", rsp_err, 0);
        nrsp++;
      end
      pushed = cmd_valid && cmd_ready;
      nxt();
      if (pushed) begin
        k++;
        if (k == 6) cmd_valid = 1'b0;
        else load(k);
      end
    end
    check("b2b_pushes", k, 6);
    check("b2b_rsp_cnt", nrsp, 6);
    echo = 1'b0;

    // invalid select 0: no bus activity, error response
    put(1'b1, 2'd0, 5'd9, 32'hFFFF_FFFF);
    mid();
    nxt();
    cmd_valid = 1'b0;
    mid();
    check("s0_c1_xfer", transfer, 0);
    check("s0_c1_vld", rsp_valid, 0);
    nxt();
    mid();
    check("s0_xfer", transfer, 0);
    check("s0_pen", penable, 0);
    check("s0_wa", write_paddr, 0);
    check("s0_vld", rsp_valid, 1);
    check("s0_err", rsp_err, 1);
    check("s0_data", rsp_data, 0);
    nxt();
    mid();
    check("s0_after_vld", rsp_valid, 0);
    check("s0_after_err", rsp_err, 0);
    nxt();

    // invalid select 3 on a read
    rd_fix = 32'h1111_2222;
    put(1'b0, 2'd3, 5'd6, 32'h0);
    mid();
    nxt();
    cmd_valid = 1'b0;
    mid();
    nxt();
    mid();
    check("s3_xfer", transfer, 0);
    check("s3_vld", rsp_valid, 1);
    check("s3_err", rsp_err, 1);
    check("s3_data", rsp_data, 0);
    nxt();

    // bus never ready
    bus_ready = 1'b0;
    rd_fix    = 32'h5555_AAAA;
    put(1'b0, 2'd1, 5'd7, 32'h0);
    mid();
    nxt();
    cmd_valid = 1'b0;
    mid();
    nxt();
    mid();
    nxt();
`ifdef APB_SEQ_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      if (rsp_valid) seen++;
      if (i == 14) check("to_last_pen", penable, 1);
      nxt();
    end
    check("to_early_rsp", seen, 0);
    mid();
    check("to_vld", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 0);
    check("to_pen", penable, 0);
    nxt();
    put(1'b1, 2'd2, 5'd4, 32'h0000_0077);
    mid();
    nxt();
    cmd_valid = 1'b0;
    mid();
    nxt();
    mid();
    nxt();
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      mid();
      if (rsp_valid) seen++;
      nxt();
    end
    check("nto_rsp", seen, 0);
    mid();
    check("nto_pen", penable, 1);
    check("nto_ra", apb_read_paddr, 7);
    nxt();
`endif

    // reset while in ACCESS aborts silently
    mid();
    check("ra_in_access", penable, 1);
    Reset = 1'b1;
    nxt();
    Reset     = 1'b0;
    bus_ready = 1'b1;
    mid();
    check("ra_xfer", transfer, 0);
    check("ra_pen", penable, 0);
    check("ra_pwr", pwrite, 0);
    check("ra_psel", Psel, 0);
    check("ra_wa", write_paddr, 0);
    check("ra_ra", apb_read_paddr, 0);
    check("ra_wd", write_data, 0);
    check("ra_vld", rsp_valid, 0);
    check("ra_busy", busy, 0);
    check("ra_data", rsp_data, 0);
    nxt();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      mid();
      if (rsp_valid || transfer) seen++;
      nxt();
    end
    check("ra_quiet", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
